// File: rtl/elastic_pipeline.sv
// Generic in-order register pipeline with valid/ready backpressure, bubble
// collapsing, per-stage flush and accepted/emitted transfer counters.
module elastic_pipeline #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  input  logic [DEPTH-1:0]           flush_mask,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           acc_cnt,
  output logic [CNT_W-1:0]           emit_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  r_valid;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [CNT_W-1:0]  r_acc_cnt;
  logic [CNT_W-1:0]  r_emit_cnt;

  logic [DEPTH:0]    w_rdy;
  logic [DEPTH-1:0]  w_src_vld;
  logic [DATA_W-1:0] w_src_data [DEPTH];
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [OCC_W-1:0]  w_occ;

  // Ready ripples backwards from the consumer; an empty stage always accepts,
  // which is what lets bubbles close up while the output is stalled.
  always_comb begin
    logic v_rdy;
    v_rdy        = out_ready;
    w_rdy        = '0;
    w_rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      v_rdy    = !r_valid[i] | v_rdy;
      w_rdy[i] = v_rdy;
    end
  end

  always_comb begin
    w_src_vld     = {r_valid[DEPTH-2:0], in_valid};
    w_src_data[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_data[i] = r_data[i-1];
    end
  end

  assign w_in_xfer  = in_valid & w_rdy[0];
  assign w_out_xfer = r_valid[DEPTH-1] & out_ready;

  // Stage registers: flush beats load, load beats hold. Flushing only clears
  // valid, so a payload leaving a flushed stage still advances normally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_mask[i]) begin
          r_valid[i] <= 1'b0;
        end else if (w_rdy[i]) begin
          r_valid[i] <= w_src_vld[i];
          if (w_src_vld[i]) begin
            r_data[i] <= w_src_data[i];
          end
        end
      end
    end
  end

  // Counters see the raw handshakes, so a transfer that is flushed on the
  // same edge is still counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_cnt  <= '0;
      r_emit_cnt <= '0;
    end else begin
      if (w_in_xfer) begin
        r_acc_cnt <= r_acc_cnt + 1'b1;
      end
      if (w_out_xfer) begin
        r_emit_cnt <= r_emit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    logic [OCC_W-1:0] v_cnt;
    v_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_cnt = v_cnt + OCC_W'(r_valid[i]);
    end
    w_occ = v_cnt;
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign occupancy = w_occ;
  assign acc_cnt   = r_acc_cnt;
  assign emit_cnt  = r_emit_cnt;

endmodule
